reg_dump_unit: RTL

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

---
 rtl/reg_dump_unit.sv | 93 +++++++++
 1 files changed

// File: rtl/reg_dump_unit.sv
// Streams every register-file entry out as a valid/ready beat stream.
// Each beat takes one READ cycle to capture and at least one SEND cycle to hand off.
module reg_dump_unit #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned BITS    = 64,
    parameter bit          SKIP_X0 = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic [$clog2(DEPTH)-1:0] rf_addr,
    input  logic [BITS-1:0]          rf_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BITS-1:0]          out_data,
    output logic [$clog2(DEPTH)-1:0] out_addr,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LastIdx  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] FirstIdx = AW'(SKIP_X0);

    typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [BITS-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    cnt_d   = FirstIdx;
                    state_d = StRead;
                end
            end
            StRead: begin
                data_d  = rf_data;
                addr_d  = cnt_q;
                state_d = StSend;
            end
            StSend: begin
                if (out_ready) begin
                    // Increment only below the last index so the counter never wraps.
                    if (addr_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q + AW'(1);
                        state_d = StRead;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    // The counter only changes on entry to READ, so it also holds the address afterwards.
    assign rf_addr   = (state_q == StIdle) ? '0 : cnt_q;
    assign out_valid = (state_q == StSend);
    assign out_last  = (state_q == StSend) && (addr_q == LastIdx);
    assign out_addr  = addr_q;
    assign out_data  = data_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule
